// File: rtl/mpt_plb_if.sv
// Shared types and the bus interface for the MPT permission lookaside buffer.
// The package comes first so both the interface and the design can import it.
package mpt_plb_pkg;

  localparam int XLEN       = 32;
  localparam int SDID_LEN   = 6;
  localparam int PAGE_SHIFT = 12;

  typedef enum logic [1:0] {
    ACCESS_NONE  = 2'd0,
    ACCESS_READ  = 2'd1,
    ACCESS_WRITE = 2'd2,
    ACCESS_EXEC  = 2'd3
  } mpt_access_e;

  // Bit 0 = read, bit 1 = write, bit 2 = execute.
  typedef enum logic [2:0] {
    ALLOW_NONE = 3'b000,
    ALLOW_R    = 3'b001,
    ALLOW_W    = 3'b010,
    ALLOW_RW   = 3'b011,
    ALLOW_X    = 3'b100,
    ALLOW_RX   = 3'b101,
    ALLOW_WX   = 3'b110,
    ALLOW_RWX  = 3'b111
  } mpt_permissions_e;

  typedef struct packed {
    logic [SDID_LEN-1:0] sdid;
    logic [XLEN-1:0]     spa;
    mpt_access_e         access;
  } plb_lookup_req_t;

  typedef struct packed {
    logic [SDID_LEN-1:0] sdid;
    logic [XLEN-1:0]     spa;
    mpt_permissions_e    perms;
  } plb_entry_t;

endpackage

// Lookup, response, refill and flush signals of the PLB grouped as one bus.
// slave = the PLB itself, master = the requester driving it.
interface mpt_plb_if;
  import mpt_plb_pkg::*;

  logic                lookup_valid_i;
  logic                lookup_ready_o;
  plb_lookup_req_t     lookup_req_i;
  logic                resp_valid_o;
  logic                resp_hit_o;
  mpt_permissions_e    resp_perms_o;
  logic                resp_allowed_o;
  logic                refill_valid_i;
  plb_entry_t          refill_entry_i;
  logic                flush_i;
  logic                flush_sdid_valid_i;
  logic [SDID_LEN-1:0] flush_sdid_i;
  logic                busy_o;

  modport slave (
    input  lookup_valid_i, lookup_req_i,
    output lookup_ready_o,
    output resp_valid_o, resp_hit_o, resp_perms_o, resp_allowed_o,
    input  refill_valid_i, refill_entry_i,
    input  flush_i, flush_sdid_valid_i, flush_sdid_i,
    output busy_o
  );

  modport master (
    output lookup_valid_i, lookup_req_i,
    input  lookup_ready_o,
    input  resp_valid_o, resp_hit_o, resp_perms_o, resp_allowed_o,
    output refill_valid_i, refill_entry_i,
    output flush_i, flush_sdid_valid_i, flush_sdid_i,
    input  busy_o
  );

endinterface

// File: rtl/mpt_plb.sv
// MPT permission lookaside buffer: small fully-associative cache of
// (SDID, 4 KiB page) -> permission entries with a one-cycle lookup,
// refill with round-robin eviction, and a one-index-per-cycle flush scan.
module mpt_plb
  import mpt_plb_pkg::*;
#(
  parameter int PLB_ENTRIES = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  mpt_plb_if.slave bus
);

  localparam int IDX_W = (PLB_ENTRIES > 1) ? $clog2(PLB_ENTRIES) : 1;
  localparam int PPN_W = XLEN - PAGE_SHIFT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PLB_ENTRIES - 1);

  typedef enum logic {
    ST_READY = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e              r_state;
  state_e              w_state_next;

  logic [PLB_ENTRIES-1:0] r_valid;
  logic [SDID_LEN-1:0]    r_sdid  [PLB_ENTRIES];
  logic [PPN_W-1:0]       r_ppn   [PLB_ENTRIES];
  mpt_permissions_e       r_perms [PLB_ENTRIES];

  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_scan_idx;
  logic                r_flush_sdid_valid;
  logic [SDID_LEN-1:0] r_flush_sdid;

  logic                r_resp_valid;
  logic                r_resp_hit;
  mpt_permissions_e    r_resp_perms;
  logic                r_resp_allowed;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic                w_ready;
  logic                w_busy;
  logic                w_lookup_fire;
  logic                w_refill_fire;
  logic                w_flush_start;

  logic [PPN_W-1:0]    w_lk_ppn;
  logic [PPN_W-1:0]    w_rf_ppn;

  logic [PLB_ENTRIES-1:0] w_lk_match;
  logic [PLB_ENTRIES-1:0] w_rf_match;
  logic [PLB_ENTRIES-1:0] w_flush_hit;

  logic                w_lk_hit;
  logic [IDX_W-1:0]    w_lk_idx;
  mpt_permissions_e    w_lk_perms;
  logic                w_lk_allowed;

  logic                w_rf_hit;
  logic [IDX_W-1:0]    w_rf_match_idx;
  logic                w_has_invalid;
  logic [IDX_W-1:0]    w_inv_idx;
  logic [IDX_W-1:0]    w_rf_idx;
  logic                w_rf_evict;

  assign w_lk_ppn = bus.lookup_req_i.spa[XLEN-1:PAGE_SHIFT];
  assign w_rf_ppn = bus.refill_entry_i.spa[XLEN-1:PAGE_SHIFT];

  // Per-entry comparators: lookup match, refill match, flush selection.
  generate
    for (genvar gi = 0; gi < PLB_ENTRIES; gi++) begin : g_cmp
      assign w_lk_match[gi]  = r_valid[gi]
                             && (r_sdid[gi] == bus.lookup_req_i.sdid)
                             && (r_ppn[gi]  == w_lk_ppn);
      assign w_rf_match[gi]  = r_valid[gi]
                             && (r_sdid[gi] == bus.refill_entry_i.sdid)
                             && (r_ppn[gi]  == w_rf_ppn);
      assign w_flush_hit[gi] = !r_flush_sdid_valid
                             || (r_sdid[gi] == r_flush_sdid);
    end
  endgenerate

  // Lowest-index priority encoders for lookup match, refill match, free slot.
  always_comb begin
    w_lk_idx       = '0;
    w_rf_match_idx = '0;
    w_inv_idx      = '0;
    for (int i = PLB_ENTRIES - 1; i >= 0; i--) begin
      if (w_lk_match[i]) w_lk_idx       = IDX_W'(i);
      if (w_rf_match[i]) w_rf_match_idx = IDX_W'(i);
      if (!r_valid[i])   w_inv_idx      = IDX_W'(i);
    end
  end

  assign w_lk_hit      = |w_lk_match;
  assign w_rf_hit      = |w_rf_match;
  assign w_has_invalid = ~&r_valid;

  // Refill target: overwrite same page, else first free slot, else evict.
  assign w_rf_idx   = w_rf_hit      ? w_rf_match_idx :
                      w_has_invalid ? w_inv_idx      : r_rr_ptr;
  assign w_rf_evict = !w_rf_hit && !w_has_invalid;

  // Permission readout and access check for the lookup being accepted.
  always_comb begin
    w_lk_perms   = w_lk_hit ? r_perms[w_lk_idx] : ALLOW_NONE;
    w_lk_allowed = 1'b0;
    if (w_lk_hit) begin
      case (bus.lookup_req_i.access)
        ACCESS_READ:  w_lk_allowed = w_lk_perms[0];
        ACCESS_WRITE: w_lk_allowed = w_lk_perms[1];
        ACCESS_EXEC:  w_lk_allowed = w_lk_perms[2];
        default:      w_lk_allowed = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_READY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status outputs; FLUSH lasts until the last index is scanned.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_READY: begin
        w_ready = 1'b1;
        if (bus.flush_i) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_busy = 1'b1;
        if (r_scan_idx == LAST_IDX) w_state_next = ST_READY;
      end
      default: w_state_next = ST_READY;
    endcase
  end

  assign w_lookup_fire = bus.lookup_valid_i && w_ready;
  // A refill arriving together with a flush request is dropped.
  assign w_refill_fire = bus.refill_valid_i && w_ready && !bus.flush_i;
  assign w_flush_start = bus.flush_i && w_ready;

  assign bus.lookup_ready_o = w_ready;
  assign bus.busy_o         = w_busy;

  // ---------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------

  // Valid bits: set by refill, cleared by reset and by the flush scan.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else if (w_refill_fire) begin
      r_valid[w_rf_idx] <= 1'b1;
    end else if (r_state == ST_FLUSH && w_flush_hit[r_scan_idx]) begin
      r_valid[r_scan_idx] <= 1'b0;
    end
  end

  // Entry payload; meaningless while the valid bit is clear, so not reset.
  always_ff @(posedge clk_i) begin
    if (w_refill_fire) begin
      r_sdid[w_rf_idx]  <= bus.refill_entry_i.sdid;
      r_ppn[w_rf_idx]   <= w_rf_ppn;
      r_perms[w_rf_idx] <= bus.refill_entry_i.perms;
    end
  end

  // Eviction pointer moves only when a live, unrelated entry is replaced.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_refill_fire && w_rf_evict) begin
      r_rr_ptr <= r_rr_ptr + 1'b1;
    end
  end

  // Flush filter capture and scan index; the index wraps to 0 after the last.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scan_idx         <= '0;
      r_flush_sdid_valid <= 1'b0;
      r_flush_sdid       <= '0;
    end else if (w_flush_start) begin
      r_scan_idx         <= '0;
      r_flush_sdid_valid <= bus.flush_sdid_valid_i;
      r_flush_sdid       <= bus.flush_sdid_i;
    end else if (r_state == ST_FLUSH) begin
      r_scan_idx <= r_scan_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Response
  // ---------------------------------------------------------------------

  // One-cycle response strobe; result fields hold until the next response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_resp_valid   <= 1'b0;
      r_resp_hit     <= 1'b0;
      r_resp_perms   <= ALLOW_NONE;
      r_resp_allowed <= 1'b0;
    end else begin
      r_resp_valid <= w_lookup_fire;
      if (w_lookup_fire) begin
        r_resp_hit     <= w_lk_hit;
        r_resp_perms   <= w_lk_perms;
        r_resp_allowed <= w_lk_allowed;
      end
    end
  end

  assign bus.resp_valid_o   = r_resp_valid;
  assign bus.resp_hit_o     = r_resp_hit;
  assign bus.resp_perms_o   = r_resp_perms;
  assign bus.resp_allowed_o = r_resp_allowed;

endmodule

// File: tb/tb_mpt_plb.sv
// Directed bench for mpt_plb: reset, lookup/refill, eviction order, filtered
// flush timing, same-cycle interactions and reset during a flush scan.
module tb_mpt_plb;
  import mpt_plb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mpt_plb_if bus_if ();

  mpt_plb #(.PLB_ENTRIES(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.lookup_valid_i     = 1'b0;
    bus_if.lookup_req_i       = '0;
    bus_if.refill_valid_i     = 1'b0;
    bus_if.refill_entry_i     = '0;
    bus_if.flush_i            = 1'b0;
    bus_if.flush_sdid_valid_i = 1'b0;
    bus_if.flush_sdid_i       = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_lookup(input logic [5:0] sdid, input logic [31:0] spa, input mpt_access_e acc);
    bus_if.lookup_valid_i      = 1'b1;
    bus_if.lookup_req_i.sdid   = sdid;
    bus_if.lookup_req_i.spa    = spa;
    bus_if.lookup_req_i.access = acc;
  endtask

  task automatic drive_refill(input logic [5:0] sdid, input logic [31:0] spa, input mpt_permissions_e perms);
    bus_if.refill_valid_i       = 1'b1;
    bus_if.refill_entry_i.sdid  = sdid;
    bus_if.refill_entry_i.spa   = spa;
    bus_if.refill_entry_i.perms = perms;
  endtask

  task automatic check_resp(input string tag, input logic e_hit, input logic [2:0] e_perms, input logic e_allowed);
    check({tag, "_valid"},   64'(bus_if.resp_valid_o),   64'(1'b1));
    check({tag, "_hit"},     64'(bus_if.resp_hit_o),     64'(e_hit));
    check({tag, "_perms"},   64'(bus_if.resp_perms_o),   64'(e_perms));
    check({tag, "_allowed"}, 64'(bus_if.resp_allowed_o), 64'(e_allowed));
    $display("lookup %-14s hit=%0d perms=%03b allowed=%0d", tag,
             bus_if.resp_hit_o, bus_if.resp_perms_o, bus_if.resp_allowed_o);
  endtask

  task automatic lookup(input string tag, input logic [5:0] sdid, input logic [31:0] spa,
                        input mpt_access_e acc, input logic e_hit, input logic [2:0] e_perms,
                        input logic e_allowed);
    drive_lookup(sdid, spa, acc);
    tick();
    bus_if.lookup_valid_i = 1'b0;
    check_resp(tag, e_hit, e_perms, e_allowed);
  endtask

  task automatic refill(input logic [5:0] sdid, input logic [31:0] spa, input mpt_permissions_e perms);
    drive_refill(sdid, spa, perms);
    tick();
    bus_if.refill_valid_i = 1'b0;
    $display("refill sdid=%0d spa=%08h perms=%03b", sdid, spa, perms);
  endtask

  initial begin
    int cnt;
    int ready_seen;

    idle_inputs();

    // Reset with a lookup presented: reset wins, no response afterwards.
    tick();
    drive_lookup(6'd1, 32'h8000_1000, ACCESS_READ);
    do_reset();
    idle_inputs();
    check("rst_resp_valid",   64'(bus_if.resp_valid_o),   64'(0));
    check("rst_resp_hit",     64'(bus_if.resp_hit_o),     64'(0));
    check("rst_resp_perms",   64'(bus_if.resp_perms_o),   64'(0));
    check("rst_resp_allowed", 64'(bus_if.resp_allowed_o), 64'(0));
    check("rst_busy",         64'(bus_if.busy_o),         64'(0));
    check("rst_ready",        64'(bus_if.lookup_ready_o), 64'(1));
    $display("reset state checked");

    // Cold lookup misses.
    lookup("cold_miss", 6'd1, 32'h8000_1000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
    tick();
    check("strobe_one_cycle", 64'(bus_if.resp_valid_o), 64'(0));

    // Read-only page: write denied, read allowed, offset within page matches.
    refill(6'd1, 32'h8000_1000, ALLOW_R);
    lookup("ro_write", 6'd1, 32'h8000_1FFC, ACCESS_WRITE, 1'b1, 3'b001, 1'b0);
    lookup("ro_read",  6'd1, 32'h8000_1FFC, ACCESS_READ,  1'b1, 3'b001, 1'b1);
    tick();
    check("hold_hit",     64'(bus_if.resp_hit_o),     64'(1));
    check("hold_allowed", 64'(bus_if.resp_allowed_o), 64'(1));
    lookup("other_sdid", 6'd2, 32'h8000_1000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
    lookup("next_page",  6'd1, 32'h8000_2000, ACCESS_READ, 1'b0, 3'b000, 1'b0);

    // Refill of the same page overwrites in place.
    refill(6'd1, 32'h8000_1000, ALLOW_RX);
    lookup("rx_exec",  6'd1, 32'h8000_1000, ACCESS_EXEC,  1'b1, 3'b101, 1'b1);
    lookup("rx_write", 6'd1, 32'h8000_1000, ACCESS_WRITE, 1'b1, 3'b101, 1'b0);
    lookup("rx_none",  6'd1, 32'h8000_1000, ACCESS_NONE,  1'b1, 3'b101, 1'b0);

    // Eviction order: 8 pages fill 0..7, in-place overwrite keeps pointer at 0,
    // 9th page evicts entry 0, 10th evicts entry 1.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      refill(6'd3, 32'h1000_0000 + 32'(i) * 32'h1000, ALLOW_R);
    end
    refill(6'd3, 32'h1000_3000, ALLOW_RW);
    refill(6'd3, 32'h1000_8000, ALLOW_W);
    lookup("ev_p0_gone", 6'd3, 32'h1000_0000, ACCESS_READ,  1'b0, 3'b000, 1'b0);
    lookup("ev_p3_rw",   6'd3, 32'h1000_3000, ACCESS_WRITE, 1'b1, 3'b011, 1'b1);
    lookup("ev_p8",      6'd3, 32'h1000_8000, ACCESS_WRITE, 1'b1, 3'b010, 1'b1);
    lookup("ev_p1_kept", 6'd3, 32'h1000_1000, ACCESS_READ,  1'b1, 3'b001, 1'b1);
    refill(6'd3, 32'h1000_9000, ALLOW_X);
    lookup("ev_p1_gone", 6'd3, 32'h1000_1000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
    lookup("ev_p2_kept", 6'd3, 32'h1000_2000, ACCESS_READ, 1'b1, 3'b001, 1'b1);
    lookup("ev_p9",      6'd3, 32'h1000_9000, ACCESS_EXEC, 1'b1, 3'b100, 1'b1);
    lookup("ev_p7_kept", 6'd3, 32'h1000_7000, ACCESS_READ, 1'b1, 3'b001, 1'b1);

    // Filtered flush of SDID 1, with a same-cycle lookup (pre-flush answer)
    // and a same-cycle refill (dropped).
    do_reset();
    refill(6'd1, 32'h8000_1000, ALLOW_RW);
    refill(6'd2, 32'h8000_2000, ALLOW_R);
    refill(6'd1, 32'h8000_3000, ALLOW_RWX);
    bus_if.flush_i            = 1'b1;
    bus_if.flush_sdid_valid_i = 1'b1;
    bus_if.flush_sdid_i       = 6'd1;
    drive_lookup(6'd1, 32'h8000_1000, ACCESS_READ);
    drive_refill(6'd2, 32'h8000_5000, ALLOW_R);
    tick();
    idle_inputs();
    check_resp("flush_same_cyc", 1'b1, 3'b011, 1'b1);

    // Count FLUSH cycles; refill at scan step 2 and a second (flush-all)
    // request at step 4 must both be ignored.
    cnt = 0;
    ready_seen = 0;
    while (bus_if.busy_o === 1'b1 && cnt < 20) begin
      if (bus_if.lookup_ready_o !== 1'b0) ready_seen++;
      if (cnt == 2) drive_refill(6'd2, 32'h8000_4000, ALLOW_R);
      if (cnt == 4) begin
        bus_if.flush_i            = 1'b1;
        bus_if.flush_sdid_valid_i = 1'b0;
      end
      drive_lookup(6'd2, 32'h8000_2000, ACCESS_READ);
      tick();
      idle_inputs();
      check("no_resp_in_flush", 64'(bus_if.resp_valid_o), 64'(0));
      cnt++;
    end
    $display("flush busy for %0d cycles", cnt);
    check("flush_cycles",       64'(cnt),                   64'(8));
    check("ready_low_in_flush", 64'(ready_seen),            64'(0));
    check("post_flush_busy",    64'(bus_if.busy_o),         64'(0));
    check("post_flush_ready",   64'(bus_if.lookup_ready_o), 64'(1));
    lookup("fl_sdid1_a",  6'd1, 32'h8000_1000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
    lookup("fl_sdid1_c",  6'd1, 32'h8000_3000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
    lookup("fl_sdid2_b",  6'd2, 32'h8000_2000, ACCESS_READ, 1'b1, 3'b001, 1'b1);
    lookup("fl_rf_flush", 6'd2, 32'h8000_4000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
    lookup("fl_rf_same",  6'd2, 32'h8000_5000, ACCESS_READ, 1'b0, 3'b000, 1'b0);

    // Refill and lookup of the same page in one cycle: lookup sees old contents.
    drive_refill(6'd5, 32'h9000_0000, ALLOW_R);
    drive_lookup(6'd5, 32'h9000_0000, ACCESS_READ);
    tick();
    idle_inputs();
    check_resp("same_cyc_rf", 1'b0, 3'b000, 1'b0);
    lookup("after_rf", 6'd5, 32'h9000_0000, ACCESS_READ, 1'b1, 3'b001, 1'b1);

    // Reset in FLUSH cycle 3 aborts the scan; the flush filter matches nothing,
    // so only reset can have cleared the entries.
    do_reset();
    refill(6'd7, 32'hA000_0000, ALLOW_R);
    refill(6'd7, 32'hA000_1000, ALLOW_W);
    bus_if.flush_i            = 1'b1;
    bus_if.flush_sdid_valid_i = 1'b1;
    bus_if.flush_sdid_i       = 6'd9;
    tick();
    idle_inputs();
    check("flush_c0_busy", 64'(bus_if.busy_o), 64'(1));
    tick();
    tick();
    tick();
    check("flush_c3_busy", 64'(bus_if.busy_o), 64'(1));
    do_reset();
    check("abort_busy",  64'(bus_if.busy_o),         64'(0));
    check("abort_ready", 64'(bus_if.lookup_ready_o), 64'(1));
    check("abort_resp",  64'(bus_if.resp_valid_o),   64'(0));
    lookup("abort_e0", 6'd7, 32'hA000_0000, ACCESS_READ,  1'b0, 3'b000, 1'b0);
    lookup("abort_e1", 6'd7, 32'hA000_1000, ACCESS_WRITE, 1'b0, 3'b000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mpt_plb.md
MPT_PLB -- requirements
Module: mpt_plb

Interface
REQ-001 SHALL have parameter PLB_ENTRIES, default 8, meaning number of fully-associative entries (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port lookup_valid_i  input  1  lookup request valid.
REQ-005 SHALL have port lookup_ready_o  output  1  lookup request accepted when high with lookup_valid_i.
REQ-006 SHALL have port lookup_req_i  input  plb_lookup_req_t  SDID, SPA, access type.
REQ-007 SHALL have port resp_valid_o  output  1  one-cycle response strobe.
REQ-008 SHALL have port resp_hit_o  output  1  matching valid entry found.
REQ-009 SHALL have port resp_perms_o  output  mpt_permissions_e (3)  permissions of hit entry, 3'b000 on miss.
REQ-010 SHALL have port resp_allowed_o  output  1  hit and access type permitted.
REQ-011 SHALL have port refill_valid_i  input  1  install refill_entry_i this cycle.
REQ-012 SHALL have port refill_entry_i  input  plb_entry_t  SDID, SPA, PERMS to install.
REQ-013 SHALL have port flush_i  input  1  start invalidation scan.
REQ-014 SHALL have port flush_sdid_valid_i  input  1  restrict flush to flush_sdid_i; 0 = flush all.
REQ-015 SHALL have port flush_sdid_i  input  SDID_LEN  SDID to flush.
REQ-016 SHALL have port busy_o  output  1  high while in FLUSH state.

Function
REQ-017 SHALL implement states READY and FLUSH; lookup_ready_o = (state==READY), busy_o = (state==FLUSH).
REQ-018 Match SHALL require entry valid, SDID equal, and SPA[XLEN-1:12] equal (4 KiB page granularity).
REQ-019 Lookup accepted in cycle N SHALL produce resp_valid_o=1 in cycle N+1 only; no response backpressure.
REQ-020 resp_hit_o/resp_perms_o/resp_allowed_o SHALL be registered with resp_valid_o and hold value until next response.
REQ-021 Allowed rules: ACCESS_READ needs PERMS[0], ACCESS_WRITE needs PERMS[1], ACCESS_EXEC needs PERMS[2], ACCESS_NONE always 0, miss always 0.
REQ-022 At most one entry SHALL match; if multiple match (illegal), lowest index wins.
REQ-023 Refill in READY SHALL overwrite an entry matching SDID+page if present, else lowest-index invalid entry, else entry at round-robin pointer.
REQ-024 Round-robin pointer SHALL advance by 1 (wrap PLB_ENTRIES-1 -> 0) only on refill that evicts a valid non-matching entry.
REQ-025 Lookup and refill in same cycle: lookup SHALL see pre-refill contents.
REQ-026 flush_i in READY SHALL latch flush_sdid_valid_i/flush_sdid_i, enter FLUSH next cycle, scan index 0.
REQ-027 FLUSH SHALL examine one index per cycle, clearing valid if !latched_sdid_valid or SDID equals latched SDID; after index PLB_ENTRIES-1 SHALL return to READY (exactly PLB_ENTRIES cycles in FLUSH).
REQ-028 Lookup accepted in the same cycle flush_i asserts SHALL be answered from pre-flush contents.
REQ-029 Refill during FLUSH, or same cycle as flush_i, SHALL be dropped; flush_i during FLUSH SHALL be ignored.

Reset
REQ-030 rst_i SHALL clear all entry valid bits, pointer=0, state=READY, resp_valid_o=0, resp_hit_o=0, resp_perms_o=0, resp_allowed_o=0, busy_o=0, lookup_ready_o=1 the following cycle.
REQ-031 rst_i mid-FLUSH or with a pending response SHALL abort it; no resp_valid_o after reset.

Verification
REQ-032 Reset, lookup SDID=1 SPA=0x8000_1000 READ -> next cycle resp_valid=1, hit=0, perms=0, allowed=0.
REQ-033 Refill SDID=1 SPA=0x8000_1000 ALLOW_R, then lookup SPA=0x8000_1FFC WRITE -> hit=1, perms=3'b001, allowed=0; READ -> allowed=1.
REQ-034 Fill 8 distinct pages, refill 9th -> entry 0 evicted (lookup page 0 misses), pointer=1; 10th evicts entry 1.
REQ-035 Entries for SDID 1 and 2, flush_i with flush_sdid_valid=1 sdid=1 -> busy_o high 8 cycles, lookup_ready_o=0 throughout; afterwards SDID 1 misses, SDID 2 hits.
REQ-036 Refill and lookup same page same cycle -> response hit=0; repeat lookup -> hit=1; refill during FLUSH -> later lookup misses.
REQ-037 Assert rst_i at FLUSH cycle 3 -> next cycle READY, busy_o=0, all lookups miss.
